// File: rtl/wfifo_wr_arbiter.sv
// rtl/wfifo_wr_arbiter.sv - round-robin write-port arbiter for the async FIFO write domain
module wfifo_wr_arbiter #(
  parameter int NREQ     = 4,
  parameter int DSIZE    = 8,
  parameter int PKT_MODE = 1,
  parameter int IDW      = 2
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_last,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wfull,
  input  logic                  awfull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic [IDW-1:0]        grant_id,
  output logic                  locked
);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t          state;
  logic [IDW-1:0]  rr_ptr;
  logic            turn;
  logic [IDW-1:0]  cand;
  logic            cand_found;
  logic [IDW:0]    scan_sum;
  logic            start;
  logic [NREQ-1:0] xfer;
  logic            owner_xfer;

  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] idx);
    if (idx == IDW'(NREQ - 1)) return '0;
    return idx + IDW'(1);
  endfunction

  // Round-robin scan: first valid requester at or after rr_ptr, wrapping at NREQ
  always_comb begin
    cand       = '0;
    cand_found = 1'b0;
    scan_sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_sum = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (scan_sum >= (IDW+1)'(NREQ)) scan_sum = scan_sum - (IDW+1)'(NREQ);
      if (!cand_found && req_valid[scan_sum[IDW-1:0]]) begin
        cand       = scan_sum[IDW-1:0];
        cand_found = 1'b1;
      end
    end
  end

  // A new owner starts only with two free slots; the cycle after a packet is a turnaround bubble
  assign start = (state == IDLE) && !turn && cand_found && !wfull && !awfull;

  // Ready goes to at most one requester: the locked owner, or the freshly chosen candidate
  always_comb begin
    req_ready = '0;
    if (wrst_n) begin
      if (state == LOCK) begin
        for (int i = 0; i < NREQ; i++) begin
          if (IDW'(i) == grant_id) req_ready[i] = ~wfull;
        end
      end else if (start) begin
        req_ready[cand] = 1'b1;
      end
    end
  end

  assign xfer       = req_valid & req_ready;
  assign winc       = |xfer;
  assign owner_xfer = xfer[grant_id];

  // Write data is the transferring requester's beat, zero when nothing moves
  always_comb begin
    wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (xfer[i]) wdata = req_data[i*DSIZE +: DSIZE];
    end
  end

  // Ownership FSM: lock on a non-last first beat, release and rotate priority on the last beat
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      locked   <= 1'b0;
      turn     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          turn <= 1'b0;
          if (start) begin
            grant_id <= cand;
            if (PKT_MODE != 0 && !req_last[cand]) begin
              state  <= LOCK;
              locked <= 1'b1;
            end else begin
              rr_ptr <= next_idx(cand);
            end
          end
        end
        LOCK: begin
          if (owner_xfer && req_last[grant_id]) begin
            state  <= IDLE;
            locked <= 1'b0;
            turn   <= 1'b1;
            rr_ptr <= next_idx(grant_id);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wfifo_wr_arbiter.sv
// tb/tb_wfifo_wr_arbiter.sv - directed self-checking bench for wfifo_wr_arbiter
module tb_wfifo_wr_arbiter;
  localparam int NREQ = 4;
  localparam int DSIZE = 8;
  localparam int IDW = 2;

  logic                  wclk = 1'b0;
  logic                  wrst_n;
  logic [NREQ-1:0]       req_valid, req_last;
  logic [NREQ*DSIZE-1:0] req_data;
  logic                  wfull, awfull;
  logic [NREQ-1:0]       rdy0, rdy1;
  logic                  winc0, winc1;
  logic [DSIZE-1:0]      wd0, wd1;
  logic [IDW-1:0]        gid0, gid1;
  logic                  lk0, lk1;

  int passed = 0;
  int total = 0;
  logic [7:0] sb_q[$];
  logic [7:0] sb_exp[$];
  logic sb_en = 1'b0;

  always #5 wclk = ~wclk;

  wfifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .PKT_MODE(0), .IDW(IDW)) dut0 (
    .wclk(wclk), .wrst_n(wrst_n), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(rdy0), .wfull(wfull), .awfull(awfull),
    .winc(winc0), .wdata(wd0), .grant_id(gid0), .locked(lk0));

  wfifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .PKT_MODE(1), .IDW(IDW)) dut1 (
    .wclk(wclk), .wrst_n(wrst_n), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(rdy1), .wfull(wfull), .awfull(awfull),
    .winc(winc1), .wdata(wd1), .grant_id(gid1), .locked(lk1));

  // FIFO-side monitor for the packet-mode instance
  always @(negedge wclk) begin
    if (sb_en && wrst_n && winc1) sb_q.push_back(wd1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic [3:0] er, input logic ew, input logic [7:0] ed);
    chk({tag, "_ready"}, 32'(rdy1), 32'(er));
    chk({tag, "_winc"}, 32'(winc1), 32'(ew));
    chk({tag, "_wdata"}, 32'(wd1), 32'(ed));
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic do_reset();
    wrst_n = 1'b0;
    req_valid = '0;
    req_last = '0;
    wfull = 1'b0;
    awfull = 1'b0;
    tick();
    wrst_n = 1'b1;
  endtask

  initial begin
    // reset with every requester asserting
    wrst_n = 1'b0; req_valid = 4'hF; req_last = 4'hF; req_data = '0;
    wfull = 1'b0; awfull = 1'b0;
    #3;
    chk("rst_ready0", 32'(rdy0), 32'h0);
    chk("rst_winc0", 32'(winc0), 32'h0);
    chk("rst_gid0", 32'(gid0), 32'h0);
    chk("rst_lk0", 32'(lk0), 32'h0);
    chk1("rst1", 4'h0, 1'b0, 8'h00);
    chk("rst_gid1", 32'(gid1), 32'h0);
    chk("rst_lk1", 32'(lk1), 32'h0);
    tick();
    chk("rst_hold_ready1", 32'(rdy1), 32'h0);

    // round robin single beats, PKT_MODE=0
    wrst_n = 1'b1;
    req_data = {8'h40, 8'h30, 8'h20, 8'h10};
    for (int k = 0; k < 6; k++) begin
      #2;
      chk($sformatf("rr%0d_ready", k), 32'(rdy0), 32'(1 << (k % 4)));
      chk($sformatf("rr%0d_winc", k), 32'(winc0), 32'h1);
      chk($sformatf("rr%0d_wdata", k), 32'(wd0), 32'h10 * 32'((k % 4) + 1));
      tick();
    end
    chk("rr_gid_end", 32'(gid0), 32'h1);

    // packet lock: req0 4 beats while req1 waits
    do_reset();
    req_valid = 4'b0011; req_last = 4'b0010; req_data = {8'h00, 8'h00, 8'hB1, 8'hA0};
    #2; chk1("pk_b0", 4'b0001, 1'b1, 8'hA0);
    tick();
    chk("pk_lk", 32'(lk1), 32'h1);
    chk("pk_gid", 32'(gid1), 32'h0);
    req_data[7:0] = 8'hA1;
    #2; chk1("pk_b1", 4'b0001, 1'b1, 8'hA1);
    tick();
    req_data[7:0] = 8'hA2;
    #2; chk1("pk_b2", 4'b0001, 1'b1, 8'hA2);
    tick();
    req_data[7:0] = 8'hA3; req_last = 4'b0011;
    #2; chk1("pk_b3", 4'b0001, 1'b1, 8'hA3);
    tick();
    chk("pk_unlk", 32'(lk1), 32'h0);
    req_valid = 4'b0010; req_last = 4'b0010;
    #2; chk1("pk_gap", 4'b0000, 1'b0, 8'h00);
    tick();
    #2; chk1("pk_req1", 4'b0010, 1'b1, 8'hB1);
    tick();
    chk("pk_gid1", 32'(gid1), 32'h1);
    chk("pk_lk1", 32'(lk1), 32'h0);

    // backpressure mid-packet on req2
    do_reset();
    req_valid = 4'b0100; req_last = 4'b0000; req_data = {8'h00, 8'hC0, 8'h00, 8'h00};
    #2; chk1("bp_b0", 4'b0100, 1'b1, 8'hC0);
    tick();
    req_data[23:16] = 8'hC1; wfull = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk1($sformatf("bp_full%0d", k), 4'b0000, 1'b0, 8'h00);
      chk($sformatf("bp_lk%0d", k), 32'(lk1), 32'h1);
      tick();
    end
    wfull = 1'b0;
    #2; chk1("bp_b1", 4'b0100, 1'b1, 8'hC1);
    tick();
    req_data[23:16] = 8'hC2; awfull = 1'b1;
    #2; chk1("bp_b2_awfull", 4'b0100, 1'b1, 8'hC2);
    tick();
    req_data[23:16] = 8'hC3; req_last = 4'b0100; awfull = 1'b0;
    #2; chk1("bp_b3", 4'b0100, 1'b1, 8'hC3);
    tick();
    chk("bp_unlk", 32'(lk1), 32'h0);
    chk("bp_gid", 32'(gid1), 32'h2);

    // awfull blocks a start in IDLE
    do_reset();
    sb_en = 1'b1;
    awfull = 1'b1; req_valid = 4'b0100; req_last = 4'b0100; req_data = {8'h00, 8'hD2, 8'h00, 8'h00};
    #2; chk1("af_block", 4'b0000, 1'b0, 8'h00);
    tick();
    chk("af_gid", 32'(gid1), 32'h0);
    awfull = 1'b0;
    #2; chk1("af_grant", 4'b0100, 1'b1, 8'hD2);
    tick();
    chk("af_gid2", 32'(gid1), 32'h2);

    // wrap: rr_ptr=3, req3 packet then req0
    req_valid = 4'b1001; req_last = 4'b0000; req_data = {8'hE0, 8'h00, 8'h00, 8'hF0};
    #2; chk1("wr_e0", 4'b1000, 1'b1, 8'hE0);
    tick();
    chk("wr_lk", 32'(lk1), 32'h1);
    chk("wr_gid3", 32'(gid1), 32'h3);
    req_data[31:24] = 8'hE1; req_last = 4'b1000;
    #2; chk1("wr_e1", 4'b1000, 1'b1, 8'hE1);
    tick();
    chk("wr_unlk", 32'(lk1), 32'h0);
    req_valid = 4'b0001; req_last = 4'b0001;
    #2; chk1("wr_gap", 4'b0000, 1'b0, 8'h00);
    tick();
    #2; chk1("wr_f0", 4'b0001, 1'b1, 8'hF0);
    tick();
    chk("wr_gid0", 32'(gid1), 32'h0);
    req_valid = 4'hF; req_last = 4'hF; req_data = {8'h63, 8'h62, 8'h61, 8'h60};
    #2; chk1("wr_next1", 4'b0010, 1'b1, 8'h61);
    tick();
    req_valid = '0;
    sb_en = 1'b0;
    sb_exp = '{8'hD2, 8'hE0, 8'hE1, 8'hF0, 8'h61};
    chk("sb_count", 32'(sb_q.size()), 32'(sb_exp.size()));
    for (int k = 0; k < sb_exp.size(); k++) begin
      chk($sformatf("sb_word%0d", k), (k < sb_q.size()) ? 32'(sb_q[k]) : 32'hDEAD, 32'(sb_exp[k]));
    end

    // async reset mid-packet, next owner starts from req0
    do_reset();
    req_valid = 4'b0010; req_last = 4'b0010; req_data = {8'h00, 8'h00, 8'h71, 8'h00};
    #2; chk1("ar_req1", 4'b0010, 1'b1, 8'h71);
    tick();
    req_valid = 4'b0100; req_last = 4'b0000; req_data = {8'h00, 8'h82, 8'h00, 8'h00};
    #2; chk1("ar_req2", 4'b0100, 1'b1, 8'h82);
    tick();
    chk("ar_lk_before", 32'(lk1), 32'h1);
    #2;
    wrst_n = 1'b0;
    #1;
    chk("ar_lk_async", 32'(lk1), 32'h0);
    chk("ar_gid_async", 32'(gid1), 32'h0);
    chk("ar_ready_async", 32'(rdy1), 32'h0);
    chk("ar_winc_async", 32'(winc1), 32'h0);
    tick();
    wrst_n = 1'b1; req_valid = 4'hF; req_last = 4'hF;
    #2; chk("ar_restart_ready", 32'(rdy1), 32'h1);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
